// File: rtl/fp_pkg.sv
`default_nettype none
// fp_pkg: shared constants for the single-precision FP add/subtract pipeline.
// Rev 1.0
package fp_pkg;
  localparam int FP_EXP_W = 9;
  localparam int FP_MAN_W = 23;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;
endpackage
`default_nettype wire

// File: rtl/fpaddsub_round_decide.sv
`default_nettype none
// fpaddsub_round_decide: combinational round-up decision for the four IEEE-754 modes.
// Rev 1.0
module fpaddsub_round_decide
  import fp_pkg::*;
(
  input  logic       Sgn,
  input  logic       lsb,
  input  logic       R,
  input  logic       S,
  input  logic [1:0] RoundMode,
  output logic       up
);

  always_comb begin
    up = 1'b0;
    case (RoundMode)
      RM_RNE:  up = R & (S | lsb);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = ~Sgn & (R | S);
      RM_RDN:  up = Sgn & (R | S);
      default: up = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fpaddsub_round_module.sv
`default_nettype none
// fpaddsub_round_module: final rounding stage; increments fraction, adjusts exponent, registers result.
// Rev 1.0
module fpaddsub_round_module
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Sgn,
  input  logic [EXP_W-1:0] NormE,
  input  logic [MAN_W-1:0] NormM,
  input  logic             R,
  input  logic             S,
  input  logic [1:0]       RoundMode,
  output logic [MAN_W-1:0] RoundM,
  output logic [EXP_W-1:0] RoundE,
  output logic             Inexact
);

  logic             up;
  logic [MAN_W:0]   sum;
  logic             carry;
  logic [MAN_W-1:0] next_m;
  logic [EXP_W-1:0] next_e;

  fpaddsub_round_decide u_decide (
    .Sgn       (Sgn),
    .lsb       (NormM[0]),
    .R         (R),
    .S         (S),
    .RoundMode (RoundMode),
    .up        (up)
  );

  always_comb begin
    sum   = {1'b0, NormM} + {{MAN_W{1'b0}}, up};
    carry = sum[MAN_W];
    // A carry out means the significand became 10.000..., i.e. 1.000 with exponent+1.
    next_m = carry ? '0 : sum[MAN_W-1:0];
    next_e = carry ? NormE + {{(EXP_W-1){1'b0}}, 1'b1} : NormE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RoundM  <= '0;
      RoundE  <= '0;
      Inexact <= 1'b0;
    end else begin
      RoundM  <= next_m;
      RoundE  <= next_e;
      Inexact <= R | S;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_round_module.sv
`default_nettype none
// tb_fpaddsub_round_module: directed vectors with a queued scoreboard and an independent monitor.
// Rev 1.0
module tb_fpaddsub_round_module;
  localparam int EXP_W = 9;
  localparam int MAN_W = 23;

  typedef struct {
    logic [MAN_W-1:0] m;
    logic [EXP_W-1:0] e;
    logic             inx;
    int               id;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             Sgn = 1'b0;
  logic [EXP_W-1:0] NormE = '0;
  logic [MAN_W-1:0] NormM = '0;
  logic             R = 1'b0;
  logic             S = 1'b0;
  logic [1:0]       RoundMode = 2'b00;
  logic [MAN_W-1:0] RoundM;
  logic [EXP_W-1:0] RoundE;
  logic             Inexact;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  fpaddsub_round_module dut (
    .clk       (clk),
    .rst       (rst),
    .Sgn       (Sgn),
    .NormE     (NormE),
    .NormM     (NormM),
    .R         (R),
    .S         (S),
    .RoundMode (RoundMode),
    .RoundM    (RoundM),
    .RoundE    (RoundE),
    .Inexact   (Inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, id, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_m"}, -1, 32'(RoundM), 32'h0);
    check({name, "_e"}, -1, 32'(RoundE), 32'h0);
    check({name, "_inx"}, -1, 32'(Inexact), 32'h0);
  endtask

  // Drive on the falling edge; the DUT samples on the next rising edge.
  task automatic apply(input int id, input logic sg, input logic [EXP_W-1:0] e,
                       input logic [MAN_W-1:0] m, input logic r, input logic s,
                       input logic [1:0] mode, input logic [MAN_W-1:0] xm,
                       input logic [EXP_W-1:0] xe, input logic xinx);
    exp_t x;
    @(negedge clk);
    Sgn = sg; NormE = e; NormM = m; R = r; S = s; RoundMode = mode;
    x.m = xm; x.e = xe; x.inx = xinx; x.id = id;
    sb_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("RoundM", x.id, 32'(RoundM), 32'(x.m));
        check("RoundE", x.id, 32'(RoundE), 32'(x.e));
        check("Inexact", x.id, 32'(Inexact), 32'(x.inx));
      end
    end
  end

  initial begin : driver
    int budget;
    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Exact values in every mode
    for (int md = 0; md < 4; md++)
      apply(md, 1'b0, 9'h07F, 23'h0, 1'b0, 1'b0, 2'(md), 23'h0, 9'h07F, 1'b0);
    // Exact tie at zero fraction
    apply(10, 1'b0, 9'h07F, 23'h0, 1'b1, 1'b0, 2'b00, 23'h0, 9'h07F, 1'b1);
    apply(11, 1'b0, 9'h07F, 23'h0, 1'b1, 1'b0, 2'b01, 23'h0, 9'h07F, 1'b1);
    apply(12, 1'b0, 9'h07F, 23'h0, 1'b1, 1'b0, 2'b10, 23'h1, 9'h07F, 1'b1);
    apply(13, 1'b0, 9'h07F, 23'h0, 1'b1, 1'b0, 2'b11, 23'h0, 9'h07F, 1'b1);
    // Nearest-even
    apply(20, 1'b0, 9'h080, 23'h3, 1'b0, 1'b0, 2'b00, 23'h3, 9'h080, 1'b0);
    apply(21, 1'b0, 9'h080, 23'h1, 1'b1, 1'b1, 2'b00, 23'h2, 9'h080, 1'b1);
    apply(22, 1'b0, 9'h080, 23'h1, 1'b1, 1'b0, 2'b00, 23'h2, 9'h080, 1'b1);
    apply(23, 1'b0, 9'h080, 23'h2, 1'b1, 1'b0, 2'b00, 23'h2, 9'h080, 1'b1);
    // Directed modes depend on sign
    apply(30, 1'b0, 9'h080, 23'h2, 1'b0, 1'b1, 2'b11, 23'h2, 9'h080, 1'b1);
    apply(31, 1'b1, 9'h080, 23'h2, 1'b0, 1'b1, 2'b11, 23'h3, 9'h080, 1'b1);
    apply(32, 1'b1, 9'h080, 23'h5, 1'b1, 1'b1, 2'b10, 23'h5, 9'h080, 1'b1);
    apply(33, 1'b1, 9'h080, 23'h5, 1'b1, 1'b1, 2'b01, 23'h5, 9'h080, 1'b1);
    // NormE = 0 rounds like any other exponent
    apply(34, 1'b0, 9'h000, 23'h4, 1'b1, 1'b1, 2'b00, 23'h5, 9'h000, 1'b1);
    // Carry out, including exponent wrap
    apply(40, 1'b0, 9'h1FF, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 23'h0, 9'h000, 1'b1);
    apply(41, 1'b0, 9'h081, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 23'h0, 9'h082, 1'b1);

    // Asynchronous reset mid-cycle while case 41 inputs are held
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back('{m: 23'h0, e: 9'h082, inx: 1'b1, id: 50});

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
